multi_port_slow_memory: RTL and testbench
=========================================

# multi_port_slow_memory

Parametrised multi-channel successor of the single-port slow memory model used in the chip testbench. It presents `NUM_CH` independent cache-line request ports (for example I-cache and D-cache) and shares one line-organised array between them. Requests are serialised through an arbiter, and each one completes after a fixed `LATENCY`. The block sits beside `CHIP` in the top-level testbench; its array is named `mem` so `$readmemb`/`$readmemh` can preload it hierarchically.

## Interface
- `NUM_CH`, 2: number of request channels, 1..4.
- `LINE_W`, 128: line width in bits.
- `ADDR_W`, 28: line-address width (byte address bits [31:4]).
- `DEPTH`, 1024: number of lines; must be a power of 2.
- `LATENCY`, 10: cycles from grant to `mem_ready`; must be ≥ 1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `mem_read` in `NUM_CH`: per-channel read request.
- `mem_write` in `NUM_CH`: per-channel write request.
- `mem_addr` in `NUM_CH*ADDR_W`: channel c occupies `[c*ADDR_W +: ADDR_W]`.
- `mem_wdata` in `NUM_CH*LINE_W`: channel c occupies `[c*LINE_W +: LINE_W]`.
- `mem_rdata` out `NUM_CH*LINE_W`: per-channel registered read data.
- `mem_ready` out `NUM_CH`: one-cycle completion pulse per channel.

## Operation
- Array `mem[0:DEPTH-1]` of `LINE_W` bits. It is not reset.
- Line index is `addr[log2(DEPTH)-1:0]`; upper address bits are ignored, so addresses wrap modulo `DEPTH`.
- A channel is pending when `mem_read` or `mem_write` is high. If both are high, it is treated as a write.
- The master holds request, address and wdata stable until it sees `mem_ready`, then drops the request on the next cycle.

State machine:
- **IDLE**:
  - If any channel is pending, select a grant, latch channel/op/index/wdata, load the counter with `LATENCY-1`, and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**:
  - Decrement the counter each cycle.
  - When the counter is 0, go to DONE.
- **DONE**:
  - Assert `mem_ready[g]` for exactly this cycle.
  - Read: `mem_rdata` slice g updates at the edge entering DONE.
  - Write: `mem[index]` takes the latched wdata at the edge leaving DONE.
  - Go to IDLE. New requests are not sampled during DONE.
- Ungranted channels wait. Their `mem_ready` stays 0 and their `mem_rdata` is unchanged.
- `mem_rdata` slice c holds the last read data returned to channel c until the next read on channel c completes.
- Write-then-read to the same line (any channels) returns the written data, because the array commits before the next grant.
- Request changes during BUSY/DONE are ignored; the latched copy is used.

## Timing
- A request first seen high in IDLE at edge k gives `mem_ready` high in cycle k+`LATENCY` (the cycle after edge k+`LATENCY`).
- The next grant is sampled one cycle after DONE. Back-to-back service interval is `LATENCY`+2 cycles.
- Minimum `LATENCY`=1: grant, then DONE on the next cycle.
- Reset values:
  - state IDLE, counter 0.
  - `mem_ready` all 0, `mem_rdata` all 0.
  - Round-robin pointer 0.
- Reset mid-transaction: the transaction is dropped, no `mem_ready` is issued, and an in-flight write is not committed. The master must reissue it.

## Configuration
- `MEM_RR_ARB_EN` defined: round-robin arbitration.
  - The search starts at the pointer; the pointer moves to grant+1 (mod `NUM_CH`) on each grant.
  - Each persistently pending channel is served within `NUM_CH` grants.
- `MEM_RR_ARB_EN` undefined: fixed priority, lowest channel index wins. The pointer logic is removed.

## Test plan
- **Single read:** `NUM_CH`=2, `LATENCY`=10, mem[5]=0xA5..A5; ch0 reads addr 5 -> `mem_ready[0]` pulses once, 10 cycles after the grant; rdata slice0 = 0xA5..A5; `mem_ready[1]`=0.
- **Write then read:** ch1 writes 0x1234 to addr 0x0400005 (`DEPTH`=1024), then ch0 reads addr 5 -> read returns 0x1234 (wrap-around index 5).
- **Simultaneous requests:** ch0 and ch1 read in the same cycle. With `MEM_RR_ARB_EN`, after reset ch0 then ch1 are served, and on a repeat ch1 then ch0. Without it, ch0 is always served first. The two ready pulses are 12 cycles apart.
- **Reset mid-operation:** `rst_n`=0 for 1 cycle at grant+4 of a write of 0xFF to addr 7 -> no `mem_ready`, mem[7] unchanged, all outputs 0.
- **Read and write both high:** ch0 `mem_read`=`mem_write`=1, wdata=0x55, addr 3 -> treated as write; mem[3]=0x55; rdata slice0 unchanged.
- **Minimum latency:** `LATENCY`=1, ch0 read -> `mem_ready` high on the cycle after the grant; next request granted 1 cycle after DONE.

Source files
------------

// File: rtl/multi_port_slow_memory.sv
// ---------------------------------------------------------------------------
// multi_port_slow_memory
//
// Slow cache-line memory model shared by NUM_CH independent request channels.
// Pending requests are granted one at a time. Each granted request finishes
// LATENCY cycles after its grant with a one-cycle mem_ready pulse on the
// granted channel. The line array is named `mem` so a testbench can preload
// it hierarchically.
//
// Handshake: a channel is pending while mem_read or mem_write is high. If both
// are high, the request is a write. The master holds request, address and
// wdata stable until it sees mem_ready, then drops the request. The block
// latches the request at grant time, so later input changes do not affect
// an in-flight transaction.
//
// Build option: define MEM_RR_ARB_EN for round-robin arbitration. When it is
// undefined, arbitration is fixed priority and the lowest channel wins.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   mem_read   in   [NUM_CH]         per-channel read request
//   mem_write  in   [NUM_CH]         per-channel write request
//   mem_addr   in   [NUM_CH*ADDR_W]  line address, channel c at [c*ADDR_W +: ADDR_W]
//   mem_wdata  in   [NUM_CH*LINE_W]  write line, channel c at [c*LINE_W +: LINE_W]
//   mem_rdata  out  [NUM_CH*LINE_W]  per-channel registered read data
//   mem_ready  out  [NUM_CH]         one-cycle completion pulse
//   dbg_state  out  [2]              FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ---------------------------------------------------------------------------
module multi_port_slow_memory #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 28,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        mem_read,
    input  logic [NUM_CH-1:0]        mem_write,
    input  logic [NUM_CH*ADDR_W-1:0] mem_addr,
    input  logic [NUM_CH*LINE_W-1:0] mem_wdata,
    output logic [NUM_CH*LINE_W-1:0] mem_rdata,
    output logic [NUM_CH-1:0]        mem_ready,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [LINE_W-1:0] mem [0:DEPTH-1];

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CH_W-1:0]            grant_q, grant_d;
    logic                       write_q, write_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [LINE_W-1:0]          wdata_q, wdata_d;
    logic [NUM_CH*LINE_W-1:0]   rdata_q, rdata_d;
    logic [NUM_CH-1:0]          ready_q, ready_d;

    logic [NUM_CH-1:0]          pending;
    logic                       arb_found;
    logic [CH_W-1:0]            arb_grant;

    // Address bits above the line index are ignored, so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr;

`ifdef MEM_RR_ARB_EN
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            found_hi, found_lo;
    logic [CH_W-1:0] grant_hi, grant_lo;

    // Round-robin: the lowest pending channel at or above the pointer wins.
    // If none exists, the search wraps to the lowest pending channel below it.
    always_comb begin
        pending  = mem_read | mem_write;
        found_hi = 1'b0;
        found_lo = 1'b0;
        grant_hi = '0;
        grant_lo = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending[c]) begin
                if (CH_W'(c) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    grant_hi = CH_W'(c);
                end else begin
                    found_lo = 1'b1;
                    grant_lo = CH_W'(c);
                end
            end
        end
        arb_found = found_hi | found_lo;
        arb_grant = found_hi ? grant_hi : grant_lo;
        rr_ptr_d  = rr_ptr_q;
        if (state_q == IDLE && arb_found) begin
            rr_ptr_d = (arb_grant == CH_W'(NUM_CH - 1)) ? '0 : arb_grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    // Fixed priority: a descending scan leaves the lowest pending channel.
    always_comb begin
        pending   = mem_read | mem_write;
        arb_found = 1'b0;
        arb_grant = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending[c]) begin
                arb_found = 1'b1;
                arb_grant = CH_W'(c);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = '0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    grant_d = arb_grant;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (CH_W'(c) == arb_grant) begin
                            write_d = mem_write[c];
                            idx_d   = mem_addr[c*ADDR_W +: IDX_W];
                            wdata_d = mem_wdata[c*LINE_W +: LINE_W];
                        end
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // ready and read data are registered on the edge into DONE.
                    state_d = DONE;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (CH_W'(c) == grant_q) begin
                            ready_d[c] = 1'b1;
                            if (!write_q) rdata_d[c*LINE_W +: LINE_W] = mem[idx_q];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // The write commits on the edge leaving DONE, before the next grant. The
    // rst_n gate drops a write that is cut off by reset.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == DONE && write_q) mem[idx_q] <= wdata_q;
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multi_port_slow_memory.sv
module tb_multi_port_slow_memory;
    localparam int NC = 2;
    localparam int LW = 128;
    localparam int AW = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NC-1:0]     mem_read, mem_write, mem_ready;
    logic [NC*AW-1:0]  mem_addr;
    logic [NC*LW-1:0]  mem_wdata, mem_rdata;
    logic [1:0]        dbg_state;

    logic [NC-1:0]     r1_read, r1_write, r1_ready;
    logic [NC*AW-1:0]  r1_addr;
    logic [NC*LW-1:0]  r1_wdata, r1_rdata;
    logic [1:0]        r1_state;

    int n_checks = 0;
    int n_fail   = 0;

    multi_port_slow_memory #(.NUM_CH(NC), .LINE_W(LW), .ADDR_W(AW), .DEPTH(1024), .LATENCY(10)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .dbg_state(dbg_state)
    );

    multi_port_slow_memory #(.NUM_CH(NC), .LINE_W(LW), .ADDR_W(AW), .DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(r1_read), .mem_write(r1_write),
        .mem_addr(r1_addr), .mem_wdata(r1_wdata), .mem_rdata(r1_rdata),
        .mem_ready(r1_ready), .dbg_state(r1_state)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int ch, input logic rd, input logic wr,
                             input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        mem_read[ch]             = rd;
        mem_write[ch]            = wr;
        mem_addr[ch*AW +: AW]    = addr;
        mem_wdata[ch*LW +: LW]   = wd;
    endtask

    task automatic clear_req(input int ch);
        mem_read[ch]  = 1'b0;
        mem_write[ch] = 1'b0;
    endtask

    // lat = posedges from the grant edge to the edge raising mem_ready; -1 on timeout.
    task automatic wait_ready(output int lat, output logic [NC-1:0] rdy);
        lat = -1;
        rdy = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ready != '0) begin
                lat = i;
                rdy = mem_ready;
                break;
            end
        end
    endtask

    task automatic drive_req1(input int ch, input logic rd, input logic wr,
                              input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        r1_read[ch]             = rd;
        r1_write[ch]            = wr;
        r1_addr[ch*AW +: AW]    = addr;
        r1_wdata[ch*LW +: LW]   = wd;
    endtask

    task automatic wait_ready1(output int lat, output logic [NC-1:0] rdy);
        lat = -1;
        rdy = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r1_ready != '0) begin
                lat = i;
                rdy = r1_ready;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = '0; mem_write = '0; mem_addr = '0; mem_wdata = '0;
        r1_read = '0; r1_write = '0; r1_addr = '0; r1_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", mem_ready); end
        n_checks++;
        if (mem_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
        n_checks++;
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        n_checks++;
        if (r1_ready !== 2'b00 || r1_rdata !== '0) begin
            n_fail++; $display("FAIL reset_dut1: got ready %b rdata %h expected 00 / 0", r1_ready, r1_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int lat;
        logic [NC-1:0] rdy;
        drive_req(1, 1'b0, 1'b1, 28'd5, {16{8'hA5}});
        wait_ready(lat, rdy);
        clear_req(1);
        n_checks++;
        if (lat !== 10 || rdy !== 2'b10) begin
            n_fail++; $display("FAIL preload_a5: got lat %0d ready %b expected 10 / 10", lat, rdy);
        end
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 28'd5, '0);
        wait_ready(lat, rdy);
        clear_req(0);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL read_latency: got %0d expected 10", lat); end
        n_checks++;
        if (rdy !== 2'b01) begin n_fail++; $display("FAIL read_ready: got %b expected 01", rdy); end
        n_checks++;
        if (mem_rdata[LW-1:0] !== {16{8'hA5}}) begin
            n_fail++; $display("FAIL read_data: got %h expected a5..a5", mem_rdata[LW-1:0]);
        end
        n_checks++;
        if (mem_rdata[2*LW-1:LW] !== '0) begin
            n_fail++; $display("FAIL read_other_slice: got %h expected 0", mem_rdata[2*LW-1:LW]);
        end
        @(negedge clk);
        n_checks++;
        if (mem_ready !== 2'b00) begin n_fail++; $display("FAIL ready_one_cycle: got %b expected 00", mem_ready); end
    endtask

    task automatic test_write_then_read();
        int lat;
        logic [NC-1:0] rdy;
        drive_req(1, 1'b0, 1'b1, 28'h0400005, 128'h1234);
        wait_ready(lat, rdy);
        clear_req(1);
        n_checks++;
        if (lat !== 10 || rdy !== 2'b10) begin
            n_fail++; $display("FAIL wr_ch1: got lat %0d ready %b expected 10 / 10", lat, rdy);
        end
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 28'd5, '0);
        wait_ready(lat, rdy);
        clear_req(0);
        n_checks++;
        if (mem_rdata[LW-1:0] !== 128'h1234) begin
            n_fail++; $display("FAIL wrap_read: got %h expected 1234", mem_rdata[LW-1:0]);
        end
        n_checks++;
        if (mem_rdata[2*LW-1:LW] !== '0) begin
            n_fail++; $display("FAIL write_no_rdata: got %h expected 0", mem_rdata[2*LW-1:LW]);
        end
        @(negedge clk);
    endtask

    task automatic test_read_write_both();
        int lat;
        logic [NC-1:0] rdy;
        drive_req(0, 1'b1, 1'b1, 28'd3, 128'h55);
        wait_ready(lat, rdy);
        clear_req(0);
        n_checks++;
        if (rdy !== 2'b01 || lat !== 10) begin
            n_fail++; $display("FAIL both_ready: got lat %0d ready %b expected 10 / 01", lat, rdy);
        end
        n_checks++;
        if (mem_rdata[LW-1:0] !== 128'h1234) begin
            n_fail++; $display("FAIL both_rdata_kept: got %h expected 1234", mem_rdata[LW-1:0]);
        end
        @(negedge clk);
        drive_req(1, 1'b1, 1'b0, 28'd3, '0);
        wait_ready(lat, rdy);
        clear_req(1);
        n_checks++;
        if (mem_rdata[2*LW-1:LW] !== 128'h55) begin
            n_fail++; $display("FAIL both_committed: got %h expected 55", mem_rdata[2*LW-1:LW]);
        end
        @(negedge clk);
    endtask

    // Channel 0 reads line 5 (0x1234) and channel 1 reads line 3 (0x55) together.
    task automatic test_simultaneous(input logic [NC-1:0] exp_first);
        int lat1, lat2;
        logic [NC-1:0] rdy1, rdy2;
        drive_req(0, 1'b1, 1'b0, 28'd5, '0);
        drive_req(1, 1'b1, 1'b0, 28'd3, '0);
        wait_ready(lat1, rdy1);
        if (rdy1[0]) clear_req(0);
        else         clear_req(1);
        wait_ready(lat2, rdy2);
        clear_req(0);
        clear_req(1);
        n_checks++;
        if (rdy1 !== exp_first || lat1 !== 10) begin
            n_fail++; $display("FAIL sim_first: got ready %b lat %0d expected %b / 10", rdy1, lat1, exp_first);
        end
        n_checks++;
        if (rdy2 !== ~exp_first) begin
            n_fail++; $display("FAIL sim_second: got ready %b expected %b", rdy2, ~exp_first);
        end
        n_checks++;
        if (lat2 + 1 !== 12) begin
            n_fail++; $display("FAIL sim_interval: got %0d expected 12", lat2 + 1);
        end
        n_checks++;
        if (mem_rdata !== {128'h55, 128'h1234}) begin
            n_fail++; $display("FAIL sim_data: got %h expected 55 / 1234", mem_rdata);
        end
        @(negedge clk);
    endtask

    // A lone channel-0 grant moves a round-robin pointer to channel 1.
    task automatic test_rr_repeat();
        int lat;
        logic [NC-1:0] rdy;
        drive_req(0, 1'b1, 1'b0, 28'd5, '0);
        wait_ready(lat, rdy);
        clear_req(0);
        n_checks++;
        if (rdy !== 2'b01) begin n_fail++; $display("FAIL rr_single: got %b expected 01", rdy); end
        @(negedge clk);
`ifdef MEM_RR_ARB_EN
        test_simultaneous(2'b10);
`else
        test_simultaneous(2'b01);
`endif
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [NC-1:0] rdy;
        drive_req(0, 1'b0, 1'b1, 28'd7, 128'h77);
        wait_ready(lat, rdy);
        clear_req(0);
        n_checks++;
        if (lat !== 10 || rdy !== 2'b01) begin
            n_fail++; $display("FAIL preload_77: got lat %0d ready %b expected 10 / 01", lat, rdy);
        end
        @(negedge clk);
        drive_req(0, 1'b0, 1'b1, 28'd7, 128'hFF);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        clear_req(0);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (mem_ready !== 2'b00 || mem_rdata !== '0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got ready %b rdata %h state %0d expected 00 / 0 / 0",
                     mem_ready, mem_rdata, dbg_state);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ready != '0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_ready: got %0d pulses expected 0", seen); end
        drive_req(1, 1'b1, 1'b0, 28'd7, '0);
        wait_ready(lat, rdy);
        clear_req(1);
        n_checks++;
        if (mem_rdata[2*LW-1:LW] !== 128'h77) begin
            n_fail++; $display("FAIL mid_reset_no_commit: got %h expected 77", mem_rdata[2*LW-1:LW]);
        end
        @(negedge clk);
    endtask

    task automatic test_min_latency();
        int lat, lat2;
        logic [NC-1:0] rdy, rdy2;
        drive_req1(1, 1'b0, 1'b1, 28'd2, 128'hBEEF);
        wait_ready1(lat, rdy);
        r1_write[1] = 1'b0;
        n_checks++;
        if (lat !== 1 || rdy !== 2'b10) begin
            n_fail++; $display("FAIL min_write: got lat %0d ready %b expected 1 / 10", lat, rdy);
        end
        @(negedge clk);
        drive_req1(0, 1'b1, 1'b0, 28'd2, '0);
        wait_ready1(lat, rdy);
        r1_read[0] = 1'b0;
        n_checks++;
        if (lat !== 1 || rdy !== 2'b01) begin
            n_fail++; $display("FAIL min_read_latency: got lat %0d ready %b expected 1 / 01", lat, rdy);
        end
        n_checks++;
        if (r1_rdata[LW-1:0] !== 128'hBEEF) begin
            n_fail++; $display("FAIL min_read_data: got %h expected beef", r1_rdata[LW-1:0]);
        end
        @(negedge clk);
        drive_req1(0, 1'b1, 1'b0, 28'd2, '0);
        drive_req1(1, 1'b1, 1'b0, 28'd2, '0);
        wait_ready1(lat, rdy);
        if (rdy[0]) r1_read[0] = 1'b0;
        else        r1_read[1] = 1'b0;
        wait_ready1(lat2, rdy2);
        r1_read = '0;
        n_checks++;
        if (lat !== 1 || lat2 + 1 !== 3) begin
            n_fail++; $display("FAIL min_back_to_back: got lat %0d interval %0d expected 1 / 3", lat, lat2 + 1);
        end
        n_checks++;
        if (r1_rdata !== {128'hBEEF, 128'hBEEF}) begin
            n_fail++; $display("FAIL min_b2b_data: got %h expected beef / beef", r1_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_read_write_both();
        test_simultaneous(2'b01);
        test_rr_repeat();
        test_reset_mid();
        test_min_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
